nios2_debug_ocimem_sequencer: RTL

System-clock-domain controller for the Nios II on-chip-instrumentation (OCI) debug RAM. It decodes the ocimem action strobes and 38-bit JTAG data word produced by the debug slave and sequences single-port RAM reads and writes, with address auto-increment. It arbitrates the same RAM port between the JTAG debugger and the CPU's debug-mode data master. It returns read data and status through MonDReg, monitor_ready and monitor_error, which feed back into the debug slave's scan chain.

---
 rtl/nios2_debug_ocimem_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/nios2_debug_ocimem_sequencer.sv
// ---------------------------------------------------------------------------
// nios2_debug_ocimem_sequencer
//
// System-clock-domain sequencer for the Nios II OCI debug RAM. It decodes the
// ocimem action strobes coming out of the JTAG debug slave and turns them
// into single-port RAM reads and writes, auto-incrementing the debug address
// after every data transfer. The same RAM port is shared with the CPU's
// debug-mode data master; a debug strobe always wins an idle port.
//
// Ports:
//   clk, reset_n               system clock, asynchronous active-low reset
//   jdo[37:0]                  JTAG data word (address, read flag, data)
//   take_action_ocimem_a       set address, optionally read
//   take_action_ocimem_b       write data at the debug address
//   take_no_action_ocimem_a    read next word at the debug address
//   cpu_req/we/addr/wdata      CPU request (level, held until cpu_ack)
//   cpu_ack, cpu_rdata         CPU completion pulse and read data
//   ram_addr/wdata/wr/rd       RAM command (read data returns one cycle later)
//   ram_rdata                  RAM read data
//   MonDReg                    read data returned to the debugger
//   monitor_ready              last debug command has completed
//   monitor_error              a debug command was dropped (sticky)
// ---------------------------------------------------------------------------
module nios2_debug_ocimem_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        IDLE,
        DRD,
        DCAP,
        DWR,
        CRD,
        CCAP
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] cpu_rdata_q;
    // Set when the pending DWR cycle belongs to the CPU rather than the
    // debugger; the CPU write shares the DWR state but uses its own address
    // and data and must leave the debug-side registers alone.
    logic              cpu_op;

    logic              strobe_any;
    logic              rd_flag;
    logic [ADDR_W-1:0] jdo_addr;
    logic [DATA_W-1:0] jdo_wdata;
    logic              unused_jdo;

    assign strobe_any = take_action_ocimem_a | take_action_ocimem_b
                      | take_no_action_ocimem_a;
    assign rd_flag    = jdo[35];
    assign jdo_addr   = jdo[10 +: ADDR_W];
    assign jdo_wdata  = jdo[3 +: DATA_W];
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // CPU read data is forwarded straight from the RAM during the cycle the
    // ack is raised, then held in a register afterwards.
    assign cpu_rdata = (state == CCAP) ? ram_rdata : cpu_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and RAM command decode. All RAM outputs are zero outside
    // the states that actually access the RAM, so reset and IDLE issue no
    // access. Debug strobes are examined before cpu_req so the debugger
    // always gets an idle port first.
    always_comb begin
        state_next = state;
        ram_rd     = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        cpu_ack    = 1'b0;

        case (state)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    if (rd_flag) begin
                        state_next = DRD;
                    end
                end else if (take_action_ocimem_b) begin
                    state_next = DWR;
                end else if (take_no_action_ocimem_a) begin
                    state_next = DRD;
                end else if (cpu_req) begin
                    state_next = cpu_we ? DWR : CRD;
                end
            end
            DRD: begin
                ram_rd     = 1'b1;
                ram_addr   = dbg_addr;
                state_next = DCAP;
            end
            DCAP: begin
                state_next = IDLE;
            end
            DWR: begin
                ram_wr = 1'b1;
                if (cpu_op) begin
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_wdata;
                    cpu_ack   = 1'b1;
                end else begin
                    ram_addr  = dbg_addr;
                    ram_wdata = wdata;
                end
                state_next = IDLE;
            end
            CRD: begin
                ram_rd     = 1'b1;
                ram_addr   = cpu_addr;
                state_next = CCAP;
            end
            CCAP: begin
                cpu_ack    = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers. Strobes are only accepted in IDLE; any strobe seen
    // in another state is dropped and flagged through monitor_error, which
    // stays set until the next accepted ocimem_a.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbg_addr      <= '0;
            wdata         <= '0;
            cpu_op        <= 1'b0;
            cpu_rdata_q   <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_action_ocimem_a) begin
                        dbg_addr      <= jdo_addr;
                        monitor_error <= 1'b0;
                        monitor_ready <= ~rd_flag;
                        cpu_op        <= 1'b0;
                    end else if (take_action_ocimem_b) begin
                        wdata         <= jdo_wdata;
                        monitor_ready <= 1'b0;
                        cpu_op        <= 1'b0;
                    end else if (take_no_action_ocimem_a) begin
                        monitor_ready <= 1'b0;
                        cpu_op        <= 1'b0;
                    end else if (cpu_req) begin
                        cpu_op        <= 1'b1;
                    end
                end
                DCAP: begin
                    MonDReg       <= ram_rdata;
                    dbg_addr      <= dbg_addr + 1'b1;
                    monitor_ready <= 1'b1;
                end
                DWR: begin
                    if (!cpu_op) begin
                        dbg_addr      <= dbg_addr + 1'b1;
                        monitor_ready <= 1'b1;
                    end
                end
                CCAP: begin
                    cpu_rdata_q <= ram_rdata;
                end
                default: begin
                end
            endcase

            if (state != IDLE && strobe_any) begin
                monitor_error <= 1'b1;
            end
        end
    end

endmodule
